// File: rtl/fft_input_framer.sv
// fft_input_framer: serial-to-parallel 8-sample framer with ping-pong banks feeding the FFT
module fft_input_framer #(
  parameter int DW = 8,
  parameter bit BITREV = 1'b0
) (
  input  logic          clk_1,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3,
  output logic [DW-1:0] out4,
  output logic [DW-1:0] out5,
  output logic [DW-1:0] out6,
  output logic [DW-1:0] out7,
  output logic [DW-1:0] out8,
  output logic          f_valid,
  input  logic          f_ready,
  output logic [7:0]    frame_cnt
);
  logic [DW-1:0] bank [2][8];
  logic [DW-1:0] rd [8];
  logic [1:0]    full;
  logic          wr_bank, rd_bank;
  logic [2:0]    wr_idx, slot;
  logic          accept, consume, done;
  // handshake decode; ready depends on state only so upstream never sees a loop through s_valid
  always_comb begin
    s_ready = !full[wr_bank];
    f_valid = full[rd_bank];
    accept  = s_valid && s_ready;
    consume = f_valid && f_ready;
    done    = accept && wr_idx == 3'd7;
    slot    = BITREV ? {wr_idx[0], wr_idx[1], wr_idx[2]} : wr_idx;
  end
  // bank pointers, full flags and delivered-frame counter; flush wins over accept and consume
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      frame_cnt <= '0;
    end else if (flush) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      full <= (full & ~(2'(consume) << rd_bank)) | (2'(done) << wr_bank);
      if (accept) wr_idx <= wr_idx + 3'd1;
      if (done) wr_bank <= !wr_bank;
      if (consume) begin
        rd_bank   <= !rd_bank;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
  // sample storage; contents survive flush and are hidden by f_valid instead
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 8; k++)
          bank[b][k] <= '0;
    end else if (!flush && accept) begin
      bank[wr_bank][slot] <= s_data;
    end
  end
  // parallel frame view, zeroed whenever no complete frame is presented
  always_comb begin
    for (int k = 0; k < 8; k++)
      rd[k] = f_valid ? bank[rd_bank][k] : '0;
  end
  assign out1 = rd[0];
  assign out2 = rd[1];
  assign out3 = rd[2];
  assign out4 = rd[3];
  assign out5 = rd[4];
  assign out6 = rd[5];
  assign out7 = rd[6];
  assign out8 = rd[7];
endmodule
